// File: rtl/div_iter_pkg.sv
// Shared encodings for the iterative divider so hazard/debug logic can decode state.
package div_iter_pkg;

  typedef enum logic [1:0] {
    DIV_IDLE = 2'd0,
    DIV_BUSY = 2'd1,
    DIV_DONE = 2'd2
  } div_state_e;

  localparam int DIV_WIDTH  = 32;
  localparam int DIV_CYCLES = DIV_WIDTH + 1;

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider for DIV/DIVU in E; stalls the pipeline while iterating
// and returns {remainder, quotient} for one cycle in DONE.
module div_iter
  import div_iter_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               div_startE,
  input  logic               div_signedE,
  input  logic [WIDTH-1:0]   srcaE,
  input  logic [WIDTH-1:0]   srcbE,
  input  logic               div_cancel,
  output logic               divstall,
  output logic [2*WIDTH-1:0] div_result,
  output logic               div_result_valid
);

  localparam int CW = $clog2(WIDTH);
  localparam logic [CW-1:0]    LAST = CW'(WIDTH - 1);
  localparam logic [WIDTH-1:0] ONE  = WIDTH'(1);

  div_state_e           state_q, state_d;
  logic [CW-1:0]        cnt_q, cnt_d;
  logic [2*WIDTH-1:0]   rem_q, rem_d;
  logic [WIDTH-1:0]     b_q, b_d;
  logic                 qneg_q, qneg_d, rneg_q, rneg_d, dz_q, dz_d;

  logic [WIDTH-1:0]     a_mag, b_mag, quot, remd, q_out, r_out;
  logic [2*WIDTH-1:0]   sh;
  logic [WIDTH:0]       top, diff;

  assign a_mag = (div_signedE & srcaE[WIDTH-1]) ? (~srcaE + ONE) : srcaE;
  assign b_mag = (div_signedE & srcbE[WIDTH-1]) ? (~srcbE + ONE) : srcbE;

  // One restoring step: the bit shifted out of the upper half is kept as bit WIDTH
  // of the trial value so the subtract never loses magnitude.
  assign sh   = {rem_q[2*WIDTH-2:0], 1'b0};
  assign top  = {rem_q[2*WIDTH-1], sh[2*WIDTH-1:WIDTH]};
  assign diff = top - {1'b0, b_q};

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rem_d   = rem_q;
    b_d     = b_q;
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
    dz_d    = dz_q;
    case (state_q)
      DIV_IDLE: if (div_startE & ~div_cancel) begin
        state_d = DIV_BUSY;
        cnt_d   = '0;
        rem_d   = {{WIDTH{1'b0}}, a_mag};
        b_d     = b_mag;
        qneg_d  = div_signedE & (srcaE[WIDTH-1] ^ srcbE[WIDTH-1]);
        rneg_d  = div_signedE & srcaE[WIDTH-1];
        dz_d    = (srcbE == '0);
      end
      DIV_BUSY: begin
        rem_d = {(diff[WIDTH] ? top[WIDTH-1:0] : diff[WIDTH-1:0]), sh[WIDTH-1:1], ~diff[WIDTH]};
        cnt_d = cnt_q + CW'(1);
        if (cnt_q == LAST) state_d = DIV_DONE;
      end
      DIV_DONE: state_d = DIV_IDLE;
      default:  state_d = DIV_IDLE;
    endcase
    if (div_cancel) state_d = DIV_IDLE;
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= DIV_IDLE;
      cnt_q   <= '0;
      rem_q   <= '0;
      b_q     <= '0;
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
      dz_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rem_q   <= rem_d;
      b_q     <= b_d;
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
      dz_q    <= dz_d;
    end
  end

  assign quot = rem_q[WIDTH-1:0];
  assign remd = rem_q[2*WIDTH-1:WIDTH];

  // With a zero divisor every step succeeds, leaving |a| in the upper half; the
  // rneg fix-up then restores the raw dividend, so only the quotient needs forcing.
  assign q_out = dz_q ? '1 : (qneg_q ? (~quot + ONE) : quot);
  assign r_out = rneg_q ? (~remd + ONE) : remd;

  assign div_result_valid = (state_q == DIV_DONE) & ~div_cancel;
  assign div_result       = div_result_valid ? {r_out, q_out} : '0;
  assign divstall         = ~div_cancel &
                            (((state_q == DIV_IDLE) & div_startE) | (state_q == DIV_BUSY));

endmodule

// File: tb/tb_div_iter.sv
// Randomized and directed checks of div_iter against a plain-arithmetic reference.
module tb_div_iter;

  localparam int W   = 32;
  localparam int LAT = W + 1;

  logic            clk = 1'b0;
  logic            resetn = 1'b0;
  logic            div_startE = 1'b0;
  logic            div_signedE = 1'b0;
  logic            div_cancel = 1'b0;
  logic [W-1:0]    srcaE = '0;
  logic [W-1:0]    srcbE = '0;
  logic            divstall;
  logic [2*W-1:0]  div_result;
  logic            div_result_valid;

  int n_chk = 0;
  int n_err = 0;

  div_iter #(.WIDTH(W)) dut (
    .clk              (clk),
    .resetn           (resetn),
    .div_startE       (div_startE),
    .div_signedE      (div_signedE),
    .srcaE            (srcaE),
    .srcbE            (srcbE),
    .div_cancel       (div_cancel),
    .divstall         (divstall),
    .div_result       (div_result),
    .div_result_valid (div_result_valid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h exp %h", tag, got, exp);
    end
  endtask

  // MIPS semantics: truncating division, remainder takes dividend sign.
  function automatic logic [63:0] ref_div(input logic [31:0] a, input logic [31:0] b, input logic s);
    longint sa, sb, q, r;
    logic [63:0] qv, rv;
    if (b == 0) return {a, 32'hFFFF_FFFF};
    if (s) begin
      sa = longint'(signed'(a));
      sb = longint'(signed'(b));
    end else begin
      sa = longint'({32'd0, a});
      sb = longint'({32'd0, b});
    end
    q  = sa / sb;
    r  = sa % sb;
    qv = q;
    rv = r;
    return {rv[31:0], qv[31:0]};
  endfunction

  // Starts a divide and leaves div_startE high through DONE, as the pipeline would.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s, input string tag);
    int stall;
    bit got;
    logic [63:0] exp;
    exp = ref_div(a, b, s);
    @(posedge clk); #1;
    div_startE = 1'b1; div_signedE = s; srcaE = a; srcbE = b;
    stall = 0; got = 0;
    for (int i = 0; i < LAT + 10 && !got; i++) begin
      @(negedge clk);
      if (div_result_valid) begin
        got = 1;
        chk({tag, "_res"}, div_result, exp);
        chk({tag, "_stall_done"}, divstall, 0);
      end else if (divstall) stall++;
    end
    chk({tag, "_valid_seen"}, got, 1);
    chk({tag, "_stall_cycles"}, stall, LAT);
  endtask

  task automatic drop_start(input string tag);
    @(posedge clk); #1;
    div_startE = 1'b0;
    @(negedge clk);
    chk({tag, "_idle_stall"}, divstall, 0);
    chk({tag, "_idle_valid"}, div_result_valid, 0);
  endtask

  initial begin
    int vcount;
    logic [31:0] a, b;
    logic s;

    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_stall", divstall, 0);
    chk("rst_valid", div_result_valid, 0);
    chk("rst_result", div_result, 0);
    #1 resetn = 1'b1;

    run_div(32'd100, 32'd7, 1'b0, "divu_100_7");
    drop_start("after_divu");
    run_div(-32'sd7, 32'd2, 1'b1, "div_m7_2");
    run_div(32'd7, -32'sd2, 1'b1, "div_7_m2");
    drop_start("after_b2b");
    run_div(32'h8000_0000, 32'hFFFF_FFFF, 1'b1, "div_ovf");
    drop_start("after_ovf");
    run_div(32'h1234, 32'd0, 1'b0, "divu_dz");
    run_div(32'hFFFF_FFF0, 32'd0, 1'b1, "div_dz_neg");
    drop_start("after_dz");

    // cancel in cycle 10 of a signed divide
    @(posedge clk); #1;
    div_startE = 1'b1; div_signedE = 1'b1; srcaE = -32'sd100; srcbE = 32'd3;
    repeat (10) @(posedge clk);
    #1 div_cancel = 1'b1;
    @(negedge clk);
    chk("cancel_stall", divstall, 0);
    chk("cancel_valid", div_result_valid, 0);
    @(posedge clk); #1;
    div_cancel = 1'b0; div_startE = 1'b0;
    vcount = 0;
    repeat (40) begin
      @(negedge clk);
      if (div_result_valid || divstall) vcount++;
    end
    chk("cancel_quiet", vcount, 0);
    run_div(32'd9, 32'd3, 1'b0, "post_cancel");
    drop_start("after_cancel");

    // asynchronous reset while BUSY
    @(posedge clk); #1;
    div_startE = 1'b1; div_signedE = 1'b0; srcaE = 32'd1000; srcbE = 32'd7;
    repeat (5) @(posedge clk);
    #1 div_startE = 1'b0;
    @(negedge clk);
    chk("busy_stall", divstall, 1);
    #1 resetn = 1'b0;
    #1;
    chk("arst_stall", divstall, 0);
    chk("arst_valid", div_result_valid, 0);
    chk("arst_result", div_result, 0);
    @(posedge clk); #1 resetn = 1'b1;
    run_div(32'd1000, 32'd7, 1'b0, "post_reset");
    drop_start("after_reset");

    for (int n = 0; n < 24; n++) begin
      a = $urandom;
      s = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 9))
        0:       b = 32'd0;
        1, 2, 3: b = ($urandom_range(0, 1) != 0) ? -32'($urandom_range(1, 15)) : 32'($urandom_range(1, 15));
        4:       b = 32'hFFFF_FFFF;
        default: b = $urandom;
      endcase
      if ($urandom_range(0, 4) == 0) a = 32'h8000_0000;
      run_div(a, b, s, $sformatf("rnd%0d", n));
      if ($urandom_range(0, 1) != 0) drop_start($sformatf("rnd%0d", n));
    end
    drop_start("final");

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
